// File: rtl/sm83_adr_seq_if.sv
// Command channel and address-latch control bundle for the SM83 address sequencer.
// The slave modport is the sequencer's view. The master modport is the view of
// whatever issues commands and observes the latch controls.
interface sm83_adr_seq_if #(
    parameter int LEN_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 mem_wait;
    logic                 abort;
    logic                 ctl_al_we;
    logic                 ctl_al_hi_ff;
    logic                 ctl_inc_oe;
    logic                 ctl_inc_dec;
    logic                 ctl_inc_cy;
    logic                 step;
    logic                 busy;
    logic                 done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, mem_wait, abort,
        output cmd_ready, ctl_al_we, ctl_al_hi_ff, ctl_inc_oe, ctl_inc_dec,
               ctl_inc_cy, step, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_len, mem_wait, abort,
        input  cmd_ready, ctl_al_we, ctl_al_hi_ff, ctl_inc_oe, ctl_inc_dec,
               ctl_inc_cy, step, busy, done
    );
endinterface

// File: rtl/sm83_adr_seq.sv
// SM83 address latch/incrementer sequencer.
// Accepts one address command at a time. It runs the command as a single load, a single
// inc/dec step, or a multi-beat inc/dec burst. The latch controls are decoded
// combinationally from the registered state, so they settle well before the
// latch samples them on the falling edge. They also react to the live mem_wait
// and abort inputs.
module sm83_adr_seq #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    sm83_adr_seq_if.slave       bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_LOAD      = 3'd1;
    localparam logic [2:0] OP_LOAD_HI   = 3'd2;
    localparam logic [2:0] OP_INC       = 3'd3;
    localparam logic [2:0] OP_DEC       = 3'd4;
    localparam logic [2:0] OP_BURST_INC = 3'd5;
    localparam logic [2:0] OP_BURST_DEC = 3'd6;
    localparam logic [2:0] OP_LOAD_INC  = 3'd7;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [LEN_WIDTH-1:0] beats_left_q, beats_left_d;

    logic cmd_ready_s;
    logic al_we_s;
    logic al_hi_ff_s;
    logic inc_oe_s;
    logic inc_dec_s;
    logic inc_cy_s;
    logic step_s;
    logic done_s;

    // State, latched opcode and remaining beat count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Next-state logic and latch-control decode. All outputs default to idle.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        beats_left_d = beats_left_q;
        cmd_ready_s  = 1'b0;
        al_we_s      = 1'b0;
        al_hi_ff_s   = 1'b0;
        inc_oe_s     = 1'b0;
        inc_dec_s    = 1'b0;
        inc_cy_s     = 1'b0;
        step_s       = 1'b0;
        done_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort is meaningless here; a command offered alongside it still goes in
                cmd_ready_s = reset;
                if (bus.cmd_valid && reset) begin
                    op_d = bus.cmd_op;
                    case (bus.cmd_op)
                        OP_BURST_INC, OP_BURST_DEC: begin
                            if (bus.cmd_len == '0) begin
                                // zero-length burst degenerates to a NOP: one cycle, done, no write
                                op_d    = OP_NOP;
                                state_d = S_LOAD;
                            end else begin
                                beats_left_d = bus.cmd_len;
                                state_d      = S_RUN;
                            end
                        end
                        OP_LOAD_INC: begin
                            beats_left_d = bus.cmd_len;
                            state_d      = S_LOAD;
                        end
                        default: begin
                            state_d = S_LOAD;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_LOAD: begin
                if (bus.abort) begin
                    state_d      = S_IDLE;
                    beats_left_d = '0;
                end else if (bus.mem_wait) begin
                    state_d = S_LOAD;
                end else begin
                    case (op_q)
                        OP_LOAD, OP_LOAD_INC: begin
                            al_we_s = 1'b1;
                        end
                        OP_LOAD_HI: begin
                            al_we_s    = 1'b1;
                            al_hi_ff_s = 1'b1;
                        end
                        OP_INC: begin
                            al_we_s  = 1'b1;
                            inc_oe_s = 1'b1;
                            inc_cy_s = 1'b1;
                        end
                        OP_DEC: begin
                            al_we_s   = 1'b1;
                            inc_oe_s  = 1'b1;
                            inc_cy_s  = 1'b1;
                            inc_dec_s = 1'b1;
                        end
                        default: begin
                            al_we_s = 1'b0;
                        end
                    endcase
                    step_s = al_we_s;
                    if ((op_q == OP_LOAD_INC) && (beats_left_q != '0)) begin
                        state_d = S_RUN;
                    end else begin
                        done_s  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_RUN: begin
                if (bus.abort) begin
                    state_d      = S_IDLE;
                    beats_left_d = '0;
                end else if (bus.mem_wait) begin
                    state_d = S_RUN;
                end else begin
                    al_we_s      = 1'b1;
                    inc_oe_s     = 1'b1;
                    inc_cy_s     = 1'b1;
                    inc_dec_s    = (op_q == OP_BURST_DEC);
                    step_s       = 1'b1;
                    beats_left_d = beats_left_q - LEN_WIDTH'(1);
                    if (beats_left_q == LEN_WIDTH'(1)) begin
                        done_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            default: begin
                state_d      = S_IDLE;
                beats_left_d = '0;
            end
        endcase
    end

    assign bus.cmd_ready    = cmd_ready_s;
    assign bus.ctl_al_we    = al_we_s;
    assign bus.ctl_al_hi_ff = al_hi_ff_s;
    assign bus.ctl_inc_oe   = inc_oe_s;
    assign bus.ctl_inc_dec  = inc_dec_s;
    assign bus.ctl_inc_cy   = inc_cy_s;
    assign bus.step         = step_s;
    assign bus.done         = done_s;
    assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sm83_adr_seq.sv
// Self-checking bench for sm83_adr_seq. A beat-queue model predicts every output
// on every falling edge. A 16-bit address latch model, driven by the DUT
// controls, records written addresses. The recorded addresses are checked
// against hand-computed values.
module tb_sm83_adr_seq;

    logic        clk;
    logic        reset;
    logic [15:0] latch_in;
    logic [15:0] latch;
    logic [15:0] wlog[$];
    int          ndone;
    int          nbusy;
    int          n_checks;
    int          n_pass;

    // beat descriptor: {we, hi_ff, inc_oe, inc_dec, inc_cy, done}
    logic [5:0]  mq[$];

    sm83_adr_seq_if #(.LEN_WIDTH(8)) bus_if ();

    sm83_adr_seq #(.LEN_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [5:0] beat(input logic we, input logic hi, input logic oe,
                                        input logic dec, input logic cy, input logic dn);
        return {we, hi, oe, dec, cy, dn};
    endfunction

    // Model advance: on each rising edge, consume, drop or enqueue beats.
    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
        end else if (mq.size() != 0) begin
            if (bus_if.abort) mq.delete();
            else if (!bus_if.mem_wait) mq.delete(0);
        end else if (bus_if.cmd_valid) begin
            case (bus_if.cmd_op)
                3'd0: mq.push_back(beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                3'd1: mq.push_back(beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                3'd2: mq.push_back(beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
                3'd3: mq.push_back(beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
                3'd4: mq.push_back(beat(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
                3'd5, 3'd6: begin
                    if (bus_if.cmd_len == 8'd0)
                        mq.push_back(beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                    for (int i = 1; i <= int'(bus_if.cmd_len); i++)
                        mq.push_back(beat(1'b1, 1'b0, 1'b1, bus_if.cmd_op == 3'd6, 1'b1,
                                          i == int'(bus_if.cmd_len)));
                end
                default: begin
                    mq.push_back(beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bus_if.cmd_len == 8'd0));
                    for (int i = 1; i <= int'(bus_if.cmd_len); i++)
                        mq.push_back(beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, i == int'(bus_if.cmd_len)));
                end
            endcase
        end
    end

    // Per-cycle compare against the model, then the latch model and write log.
    always @(negedge clk) begin
        logic [8:0] exp_v;
        logic [8:0] act_v;
        logic [5:0] b;
        if (!reset) begin
            exp_v = 9'd0;
        end else if (mq.size() == 0) begin
            exp_v = {1'b1, 8'd0};
        end else if (bus_if.abort || bus_if.mem_wait) begin
            exp_v = {1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        end else begin
            b = mq[0];
            exp_v = {1'b0, b[5:1], b[5], 1'b1, b[0]};
        end
        act_v = {bus_if.cmd_ready, bus_if.ctl_al_we, bus_if.ctl_al_hi_ff, bus_if.ctl_inc_oe,
                 bus_if.ctl_inc_dec, bus_if.ctl_inc_cy, bus_if.step, bus_if.busy, bus_if.done};
        check("cycle_outputs", {23'd0, act_v}, {23'd0, exp_v});

        if (bus_if.ctl_al_we) begin
            if (bus_if.ctl_inc_oe) begin
                if (bus_if.ctl_inc_dec) latch = latch - {15'd0, bus_if.ctl_inc_cy};
                else                    latch = latch + {15'd0, bus_if.ctl_inc_cy};
            end else if (bus_if.ctl_al_hi_ff) begin
                latch = {8'hFF, latch_in[7:0]};
            end else begin
                latch = latch_in;
            end
            wlog.push_back(latch);
        end
        if (bus_if.done) ndone++;
        if (bus_if.busy) nbusy++;
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus_if.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Offer a command while idle. On return the bench sits in the first cycle after accept.
    task automatic run(input logic [2:0] op, input logic [7:0] len, input logic [15:0] lin);
        wait_idle();
        latch_in = lin;
        wlog.delete();
        ndone = 0;
        nbusy = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_len   = len;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 3'd0;
        bus_if.cmd_len   = 8'd0;
    endtask

    task automatic check_log(input string nm, input int n,
                             input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        logic [15:0] e;
        check({nm, "_writes"}, wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            e = (i == 0) ? e0 : (i == 1) ? e1 : e2;
            check({nm, "_addr"}, {16'd0, wlog[i]}, {16'd0, e});
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ndone    = 0;
        nbusy    = 0;
        latch    = 16'h0000;
        latch_in = 16'h0000;
        reset    = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 3'd0;
        bus_if.cmd_len   = 8'd0;
        bus_if.mem_wait  = 1'b0;
        bus_if.abort     = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, bus_if.cmd_ready, bus_if.busy, bus_if.ctl_al_we,
                                bus_if.step, bus_if.done}, 32'd0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_ready", {31'd0, bus_if.cmd_ready}, 32'd1);

        // LOAD_HI 0x1234 -> 0xFF34, step and done together, ready next cycle
        run(3'd2, 8'd0, 16'h1234);
        check("loadhi_step_done", {30'd0, bus_if.step, bus_if.done}, 32'd3);
        @(posedge clk);
        #1;
        check("loadhi_ready_after", {31'd0, bus_if.cmd_ready}, 32'd1);
        check_log("loadhi", 1, 16'hFF34, 16'h0, 16'h0);
        check("loadhi_done", ndone, 1);

        // BURST_INC 3 from 0x00FE
        run(3'd1, 8'd0, 16'h00FE);
        run(3'd5, 8'd3, 16'h0000);
        wait_idle();
        check_log("binc3", 3, 16'h00FF, 16'h0100, 16'h0101);
        check("binc3_done", ndone, 1);
        check("binc3_busy_cycles", nbusy, 3);

        // BURST_DEC 2 from 0x0001, two stall cycles right after accept
        run(3'd1, 8'd0, 16'h0001);
        run(3'd6, 8'd2, 16'h0000);
        bus_if.mem_wait = 1'b1;
        @(posedge clk);
        #1;
        check("bdec_stall_writes", wlog.size(), 0);
        @(posedge clk);
        #1;
        bus_if.mem_wait = 1'b0;
        wait_idle();
        check_log("bdec2", 2, 16'h0000, 16'hFFFF, 16'h0);
        check("bdec2_done", ndone, 1);
        check("bdec2_busy_cycles", nbusy, 4);

        // LOAD_INC 2 from 0xC000
        run(3'd7, 8'd2, 16'hC000);
        wait_idle();
        check_log("linc2", 3, 16'hC000, 16'hC001, 16'hC002);
        check("linc2_done", ndone, 1);

        // zero-length burst and NOP: one done, no write
        run(3'd5, 8'd0, 16'h5555);
        wait_idle();
        check_log("binc0", 0, 16'h0, 16'h0, 16'h0);
        check("binc0_done", ndone, 1);
        check("binc0_latch", {16'd0, latch}, 32'h0000C002);
        run(3'd0, 8'd7, 16'h5555);
        wait_idle();
        check_log("nop", 0, 16'h0, 16'h0, 16'h0);
        check("nop_done", ndone, 1);

        // abort on the 2nd beat of BURST_INC 4 from 0x0010
        run(3'd1, 8'd0, 16'h0010);
        run(3'd5, 8'd4, 16'h0000);
        @(posedge clk);
        #1;
        bus_if.abort = 1'b1;
        @(posedge clk);
        #1;
        bus_if.abort = 1'b0;
        check("abort_ready_after", {31'd0, bus_if.cmd_ready}, 32'd1);
        check_log("abort", 1, 16'h0011, 16'h0, 16'h0);
        check("abort_no_done", ndone, 0);

        // abort in IDLE is ignored; INC offered alongside it is accepted
        wait_idle();
        bus_if.abort = 1'b1;
        run(3'd3, 8'd0, 16'h0000);
        bus_if.abort = 1'b0;
        wait_idle();
        check_log("inc", 1, 16'h0012, 16'h0, 16'h0);
        run(3'd4, 8'd0, 16'h0000);
        wait_idle();
        check_log("dec", 1, 16'h0011, 16'h0, 16'h0);

        // asynchronous reset mid-burst
        run(3'd1, 8'd0, 16'h0000);
        run(3'd5, 8'd5, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_outputs", {23'd0, bus_if.cmd_ready, bus_if.busy, bus_if.ctl_al_we,
                                 bus_if.ctl_al_hi_ff, bus_if.ctl_inc_oe, bus_if.ctl_inc_dec,
                                 bus_if.ctl_inc_cy, bus_if.step, bus_if.done}, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_after", {30'd0, bus_if.cmd_ready, bus_if.busy}, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check_log("midrst", 2, 16'h0001, 16'h0002, 16'h0);
        check("midrst_no_done", ndone, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
